// File: rtl/imm_ext_sequencer.sv
// Decode-stage controller that sequences the shared Sign_Extend unit and hands the
// registered immediate to execute. Optional IMM_CNT_EN adds an immediate counter.
module imm_ext_sequencer #(
  parameter int unsigned INSTR_W = 34,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic [INSTR_W-1:0] ext_in,
  output logic [1:0]         ext_src,
  input  logic [DATA_W-1:0]  ext_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_imm,
  output logic [1:0]         out_fmt,
  output logic               out_has_imm,
  output logic               busy
`ifdef IMM_CNT_EN
  ,
  output logic [CNT_W-1:0]   imm_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] SRC_NONE = 2'b11;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [1:0]         src_q;
  logic               accept;
  logic [1:0]         cur_fmt;
  logic               capture;

  // Sign_Extend ImmSrc encoding for each instruction format.
  function automatic logic [1:0] map_src(input logic [1:0] fmt);
    logic [1:0] src;
    unique case (fmt)
      2'b01:   src = 2'b00;
      2'b10:   src = 2'b01;
      2'b11:   src = 2'b10;
      default: src = SRC_NONE;
    endcase
    return src;
  endfunction

  assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign ext_in    = instr_q;
  assign ext_src   = src_q;
  assign cur_fmt   = instr_q[INSTR_W-1:INSTR_W-2];
  // A flushed instruction must not overwrite the last transferred result.
  assign capture   = (state_q == EXT) && !flush;

  // NOTE: every output of a combinational block gets a default first, otherwise
  // paths that skip an assignment infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXT;
      EXT:     state_d = HOLD;
      HOLD:    if (out_ready) state_d = accept ? EXT : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      src_q   <= SRC_NONE;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= in_instr;
        src_q   <= map_src(in_instr[INSTR_W-1:INSTR_W-2]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_imm     <= '0;
      out_fmt     <= FMT_R;
      out_has_imm <= 1'b0;
    end else if (capture) begin
      out_imm     <= (cur_fmt == FMT_R) ? '0 : ext_imm;
      out_fmt     <= cur_fmt;
      out_has_imm <= (cur_fmt != FMT_R);
    end
  end

`ifdef IMM_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_count <= '0;
    end else if (capture && (cur_fmt != FMT_R)) begin
      imm_count <= imm_count + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] cnt_unused;
  assign cnt_unused = '0;
`endif

endmodule

// File: tb/tb_imm_ext_sequencer.sv
// Self-checking bench for imm_ext_sequencer: directed vector table, multi-cycle
// corner sequences and a randomized run against a queue-based reference model.
module tb_imm_ext_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] in_instr;
  logic        flush;
  logic [33:0] ext_in;
  logic [1:0]  ext_src;
  logic [23:0] ext_imm;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_imm;
  logic [1:0]  out_fmt;
  logic        out_has_imm;
  logic        busy;
`ifdef IMM_CNT_EN
  logic [15:0] imm_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_ext_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush),
    .ext_in(ext_in), .ext_src(ext_src), .ext_imm(ext_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_has_imm(out_has_imm),
    .busy(busy)
`ifdef IMM_CNT_EN
    , .imm_count(imm_count)
`endif
  );

  // Sign_Extend stand-in; R-format select returns junk the sequencer must discard.
  always_comb begin
    ext_imm = 24'hA5A5A5;
    case (ext_src)
      2'b00:   ext_imm = {{14{ext_in[9]}},  ext_in[9:0]};
      2'b01:   ext_imm = {{8{ext_in[15]}},  ext_in[15:0]};
      2'b10:   ext_imm = {{22{ext_in[1]}},  ext_in[1:0]};
      default: ext_imm = 24'hA5A5A5;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [33:0] instr;
    logic [23:0] imm;
    logic [1:0]  fmt;
    logic        has;
    logic [1:0]  src;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  // Reference immediate from the format rules, using signed arithmetic.
  function automatic logic [23:0] ref_imm(input logic [33:0] ins);
    int v;
    case (ins[33:32])
      2'b01:   v = int'($signed(ins[9:0]));
      2'b10:   v = int'($signed(ins[15:0]));
      2'b11:   v = int'($signed(ins[1:0]));
      default: v = 0;
    endcase
    return v[23:0];
  endfunction

  // One instruction through an idle sequencer, with optional backpressure cycles.
  task automatic run_vec(input vec_t v);
    int n;
    logic [23:0] held;
    in_instr = v.instr; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    #1;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    check("accept_timeout", n < 20, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = ~v.instr;
    check("ext_src", ext_src, v.src);
    check("ext_in", ext_in, v.instr);
    check("lat_ext_valid", out_valid, 0);
    @(negedge clk);
    check("lat_hold_valid", out_valid, 1);
    check("out_imm", out_imm, v.imm);
    check("out_fmt", out_fmt, v.fmt);
    check("out_has_imm", out_has_imm, v.has);
    held = out_imm;
    for (int i = 0; i < v.hold; i++) begin
      in_valid = 1'b1; #1;
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_imm_stable", out_imm, held);
      check("bp_ext_src_stable", ext_src, v.src);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_xfer_valid", out_valid, 0);
    check("post_xfer_busy", busy, 0);
  endtask

  // Randomized-run model state.
  logic [23:0] q_imm[$];
  logic [1:0]  q_fmt[$];
  int          age;

  initial begin
    vecs[0] = '{{2'b01, 22'h0, 10'h3FC},        24'hFFFFFC, 2'b01, 1'b1, 2'b00, 0};
    vecs[1] = '{{2'b10, 16'h1234, 16'hCCCC},    24'hFFCCCC, 2'b10, 1'b1, 2'b01, 3};
    vecs[2] = '{{2'b01, 22'h3ABCDE, 10'h00C},   24'h00000C, 2'b01, 1'b1, 2'b00, 0};
    vecs[3] = '{{2'b11, 30'h0, 2'b01},          24'h000001, 2'b11, 1'b1, 2'b10, 0};
    vecs[4] = '{{2'b11, 30'h15555554, 2'b10},   24'hFFFFFE, 2'b11, 1'b1, 2'b10, 0};
    vecs[5] = '{{2'b00, 32'hDEADBEEF},          24'h000000, 2'b00, 1'b0, 2'b11, 1};
    vecs[6] = '{{2'b10, 16'h0, 16'h7FFF},       24'h007FFF, 2'b10, 1'b1, 2'b01, 0};
    vecs[7] = '{{2'b01, 22'h0, 10'h200},        24'hFFFE00, 2'b01, 1'b1, 2'b00, 2};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ext_src", ext_src, 2'b11);
    check("rst_ext_in", ext_in, 0);
    check("rst_out_imm", out_imm, 0);
    rst = 1'b0; #1;
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-to-back S then R with in_valid and out_ready held high.
    in_instr = {2'b11, 30'h0, 2'b11}; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_instr = {2'b00, 32'h0000_03FF};
    check("b2b_ext_src_s", ext_src, 2'b10);
    @(negedge clk);
    check("b2b_valid_s", out_valid, 1);
    check("b2b_imm_s", out_imm, 24'hFFFFFF);
    check("b2b_has_s", out_has_imm, 1);
    #1 check("b2b_in_ready", in_ready, 1);
    @(negedge clk);
    check("b2b_gap_valid", out_valid, 0);
    check("b2b_busy", busy, 1);
    check("b2b_ext_src_r", ext_src, 2'b11);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_valid_r", out_valid, 1);
    check("b2b_imm_r", out_imm, 24'h000000);
    check("b2b_has_r", out_has_imm, 0);
    check("b2b_fmt_r", out_fmt, 2'b00);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle", busy, 0);

    // Flush while in EXT: the instruction never reaches execute.
    in_instr = {2'b10, 16'h0, 16'h8001}; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1; #1;
    check("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_ext_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      check("flush_ext_no_valid", out_valid, 0);
      @(negedge clk);
    end
    run_vec(vecs[2]);

    // Flush together with out_ready in HOLD: transfer completes, then IDLE.
    in_instr = vecs[6].instr; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_hold_valid", out_valid, 1);
    check("flush_hold_imm", out_imm, 24'h007FFF);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; #1;
    check("flush_hold_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("flush_hold_idle", busy, 0);
    check("flush_hold_regs_kept", out_imm, 24'h007FFF);

`ifdef IMM_CNT_EN
    begin
      logic [15:0] c0;
      c0 = imm_count;
      run_vec(vecs[0]);
      run_vec(vecs[5]);
      run_vec(vecs[6]);
      in_instr = vecs[3].instr; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("cnt_after_flush", imm_count, c0 + 16'd3);
    end
`endif

    // Reset mid-HOLD takes effect without a clock edge.
    in_instr = vecs[1].instr; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("prerst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ext_src", ext_src, 2'b11);
    check("arst_out_imm", out_imm, 0);
    check("arst_has", out_has_imm, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0; #1;
    check("arst_in_ready", in_ready, 1);
`ifdef IMM_CNT_EN
    check("arst_count", imm_count, 0);
`endif
    @(negedge clk);

    // Randomized traffic against the queue model.
    age = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic m_ready, m_xfer, m_acc, m_valid;
      check("rnd_out_valid", out_valid, (q_imm.size() > 0) && (age >= 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = {$urandom(), 2'($urandom())};
      #1;
      m_valid = (q_imm.size() > 0) && (age >= 1);
      m_xfer  = m_valid && out_ready;
      m_ready = !flush && ((q_imm.size() == 0) || m_xfer);
      m_acc   = in_valid && m_ready;
      check("rnd_in_ready", in_ready, m_ready);
      if (m_xfer) begin
        check("rnd_imm", out_imm, q_imm[0]);
        check("rnd_fmt", out_fmt, q_fmt[0]);
        check("rnd_has", out_has_imm, q_fmt[0] != 2'b00);
      end
      @(posedge clk);
      if (m_xfer) begin void'(q_imm.pop_front()); void'(q_fmt.pop_front()); end
      if (flush) begin q_imm.delete(); q_fmt.delete(); end
      if (m_acc) begin
        q_imm.push_back(ref_imm(in_instr));
        q_fmt.push_back(in_instr[33:32]);
        age = 0;
      end else if (q_imm.size() > 0) begin
        age++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
